// File: rtl/dxt_pkg.sv
// Shared types and helpers for the DAT/DCT table arbiter.
package dxt_pkg;

    typedef enum logic [1:0] {
        DXT_IDLE  = 2'd0,
        DXT_PEND  = 2'd1,
        DXT_SW_RD = 2'd2
    } dxt_arb_state_e;

    localparam int unsigned DXT_MAX_BURST_W = 4;

    // Widest RAM word the lane helper can slice; callers zero-extend into it.
    localparam int unsigned DXT_LANE_MAX_W = 512;

    // Pick 32-bit lane `word` out of a (zero-extended) RAM word.
    function automatic logic [31:0] dxt_lane_sel(input logic [DXT_LANE_MAX_W-1:0] data,
                                                 input logic [3:0]                word);
        return data[32'(word) * 32 +: 32];
    endfunction

endpackage

// File: rtl/dxt_arbiter_chk.sv
// Protocol checker for the software side of dxt_arbiter, driven from its ports.
module dxt_arbiter_chk (
    input logic clk_i,
    input logic rst_i,
    input logic sw_req_i,
    input logic sw_rd_ack_i,
    input logic sw_wr_ack_i
);

    logic busy_q;
    logic busy_d;
    logic ack_s;

    assign ack_s = sw_rd_ack_i | sw_wr_ack_i;

    // Track one outstanding software request; the ack cycle may already accept the next.
    always_comb begin
        busy_d = busy_q;
        if (sw_req_i && (!busy_q || ack_s)) begin
            busy_d = 1'b1;
        end else if (ack_s) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // Outstanding-request flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    a_no_req_while_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        !(sw_req_i && busy_q && !ack_s));

    a_acks_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(sw_rd_ack_i && sw_wr_ack_i));

    a_rd_ack_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
        sw_rd_ack_i |=> !sw_rd_ack_i);

    a_wr_ack_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
        sw_wr_ack_i |=> !sw_wr_ack_i);

endmodule

// File: rtl/dxt_arbiter.sv
// Arbitrates one single-port table RAM between the I3C controller and CSR software,
// with a bounded hardware burst so a pending software access cannot starve.
module dxt_arbiter
    import dxt_pkg::*;
#(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned DEPTH        = 128,
    parameter bit          SW_WRITABLE  = 1'b1,
    parameter int unsigned MAX_HW_BURST = 4,
    localparam int unsigned IW = $clog2(DEPTH),
    localparam int unsigned NW = WIDTH / 32,
    localparam int unsigned AW = $clog2(DEPTH * WIDTH / 8)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hw_req_i,
    input  logic             hw_we_i,
    input  logic [IW-1:0]    hw_index_i,
    input  logic [WIDTH-1:0] hw_wdata_i,
    output logic             hw_gnt_o,
    output logic             hw_rvalid_o,
    output logic [WIDTH-1:0] hw_rdata_o,
    input  logic             sw_req_i,
    input  logic             sw_req_is_wr_i,
    input  logic [AW-1:0]    sw_addr_i,
    input  logic [31:0]      sw_wr_data_i,
    output logic [31:0]      sw_rd_data_o,
    output logic             sw_rd_ack_o,
    output logic             sw_wr_ack_o,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic [IW-1:0]    mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic [WIDTH-1:0] mem_wmask_o,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned BW = $clog2(WIDTH / 8);
    localparam int unsigned WW = BW - 2;
    localparam logic [DXT_MAX_BURST_W-1:0] BURST_MAX = DXT_MAX_BURST_W'(MAX_HW_BURST);

    dxt_arb_state_e              state_q,   state_d;
    logic [DXT_MAX_BURST_W-1:0]  streak_q,  streak_d;
    logic                        is_wr_q,   is_wr_d;
    logic [IW-1:0]               index_q,   index_d;
    logic [WW-1:0]               word_q,    word_d;
    logic [31:0]                 wdata_q,   wdata_d;
    logic                        hw_rvalid_q, hw_rvalid_d;
    logic [31:0]                 rd_data_q, rd_data_d;
    logic                        rd_ack_q,  rd_ack_d;
    logic                        wr_ack_q,  wr_ack_d;

    logic                        sw_sel_s;
    logic                        hw_gnt_s;
    logic [WIDTH-1:0]            lane_mask_s;
    logic                        unused_addr_bits;

    assign unused_addr_bits = ^sw_addr_i[1:0];

    // Software wins only once the hardware streak has hit the burst limit.
    assign sw_sel_s = (state_q == DXT_PEND) && !rst_i &&
                      (!hw_req_i || (streak_q == BURST_MAX));
    assign hw_gnt_s = hw_req_i && !sw_sel_s && !rst_i;

    // One all-ones 32-bit lane at the captured word position.
    always_comb begin
        lane_mask_s = '0;
        for (int i = 0; i < int'(NW); i++) begin
            if (word_q == WW'(i)) begin
                lane_mask_s[i*32 +: 32] = 32'hFFFF_FFFF;
            end else begin
                lane_mask_s[i*32 +: 32] = 32'h0000_0000;
            end
        end
    end

    // RAM strobe mux: hardware grant, software read, software write, or nothing.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (hw_gnt_s) begin
            mem_req_o   = 1'b1;
            mem_write_o = hw_we_i;
            mem_addr_o  = hw_index_i;
            mem_wdata_o = hw_wdata_i;
            mem_wmask_o = '1;
        end else if (sw_sel_s && !is_wr_q) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = index_q;
        end else if (sw_sel_s && SW_WRITABLE) begin
            mem_req_o   = 1'b1;
            mem_write_o = 1'b1;
            mem_addr_o  = index_q;
            mem_wdata_o = {NW{wdata_q}};
            mem_wmask_o = lane_mask_s;
        end else begin
            mem_req_o   = 1'b0;
        end
    end

    // Next-state, capture and ack logic for the software path.
    always_comb begin
        state_d     = state_q;
        streak_d    = '0;
        is_wr_d     = is_wr_q;
        index_d     = index_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        rd_ack_d    = 1'b0;
        wr_ack_d    = 1'b0;
        hw_rvalid_d = hw_gnt_s && !hw_we_i;
        case (state_q)
            DXT_IDLE: begin
                if (sw_req_i) begin
                    is_wr_d = sw_req_is_wr_i;
                    index_d = sw_addr_i[AW-1:BW];
                    word_d  = sw_addr_i[BW-1:2];
                    wdata_d = sw_wr_data_i;
                    state_d = DXT_PEND;
                end else begin
                    state_d = DXT_IDLE;
                end
            end
            DXT_PEND: begin
                if (sw_sel_s) begin
                    state_d  = is_wr_q ? DXT_IDLE : DXT_SW_RD;
                    wr_ack_d = is_wr_q;
                    streak_d = '0;
                end else if (hw_gnt_s && (streak_q != BURST_MAX)) begin
                    streak_d = streak_q + 4'd1;
                end else begin
                    streak_d = streak_q;
                end
            end
            DXT_SW_RD: begin
                rd_data_d = dxt_lane_sel(DXT_LANE_MAX_W'(mem_rdata_i), 4'(word_q));
                rd_ack_d  = 1'b1;
                state_d   = DXT_IDLE;
            end
            default: begin
                state_d = DXT_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= DXT_IDLE;
            streak_q    <= '0;
            is_wr_q     <= 1'b0;
            index_q     <= '0;
            word_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            hw_rvalid_q <= 1'b0;
            rd_data_q   <= 32'h0000_0000;
            rd_ack_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            is_wr_q     <= is_wr_d;
            index_q     <= index_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            hw_rvalid_q <= hw_rvalid_d;
            rd_data_q   <= rd_data_d;
            rd_ack_q    <= rd_ack_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    assign hw_gnt_o     = hw_gnt_s;
    assign hw_rvalid_o  = hw_rvalid_q;
    assign hw_rdata_o   = hw_rvalid_q ? mem_rdata_i : '0;
    assign sw_rd_data_o = rd_data_q;
    assign sw_rd_ack_o  = rd_ack_q;
    assign sw_wr_ack_o  = wr_ack_q;

endmodule

// File: tb/tb_dxt_arbiter.sv
// Scoreboard bench for dxt_arbiter: a DAT copy (64-bit, writable) and a DCT copy (128-bit, read-only).
module tb_dxt_arbiter;

    typedef struct { logic [31:0] data; int cyc; } sw_exp_t;
    typedef struct { logic [63:0] data; int cyc; } hw_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DAT instance signals
    logic        d_hw_req = 1'b0, d_hw_we = 1'b0;
    logic [6:0]  d_hw_index = 7'd0;
    logic [63:0] d_hw_wdata = 64'd0;
    logic        d_hw_gnt, d_hw_rvalid;
    logic [63:0] d_hw_rdata;
    logic        d_sw_req = 1'b0, d_sw_is_wr = 1'b0;
    logic [9:0]  d_sw_addr = 10'd0;
    logic [31:0] d_sw_wdata = 32'd0;
    logic [31:0] d_sw_rd_data;
    logic        d_sw_rd_ack, d_sw_wr_ack;
    logic        d_mem_req, d_mem_write;
    logic [6:0]  d_mem_addr;
    logic [63:0] d_mem_wdata, d_mem_wmask;
    logic [63:0] d_mem_rdata = 64'd0;
    logic [63:0] dat_mem [128];

    // DCT instance signals
    logic         c_hw_req = 1'b0, c_hw_we = 1'b0;
    logic [6:0]   c_hw_index = 7'd0;
    logic [127:0] c_hw_wdata = 128'd0;
    logic         c_hw_gnt, c_hw_rvalid;
    logic [127:0] c_hw_rdata;
    logic         c_sw_req = 1'b0, c_sw_is_wr = 1'b0;
    logic [10:0]  c_sw_addr = 11'd0;
    logic [31:0]  c_sw_wdata = 32'd0;
    logic [31:0]  c_sw_rd_data;
    logic         c_sw_rd_ack, c_sw_wr_ack;
    logic         c_mem_req, c_mem_write;
    logic [6:0]   c_mem_addr;
    logic [127:0] c_mem_wdata, c_mem_wmask;
    logic [127:0] c_mem_rdata = 128'd0;
    logic [127:0] dct_mem [128];
    int           c_req_count = 0;

    localparam logic [63:0]  DAT5 = 64'hAAAA_BBBB_1111_2222;
    localparam logic [63:0]  DAT3 = 64'h3333_0000_CCCC_4444;
    localparam logic [127:0] DCT7 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

    sw_exp_t d_rd_q[$];
    int      d_wr_q[$];
    hw_exp_t d_hw_q[$];
    sw_exp_t c_rd_q[$];
    int      c_wr_q[$];

    dxt_arbiter #(.WIDTH(64), .DEPTH(128), .SW_WRITABLE(1'b1), .MAX_HW_BURST(4)) u_dat (
        .clk_i(clk), .rst_i(rst),
        .hw_req_i(d_hw_req), .hw_we_i(d_hw_we), .hw_index_i(d_hw_index), .hw_wdata_i(d_hw_wdata),
        .hw_gnt_o(d_hw_gnt), .hw_rvalid_o(d_hw_rvalid), .hw_rdata_o(d_hw_rdata),
        .sw_req_i(d_sw_req), .sw_req_is_wr_i(d_sw_is_wr), .sw_addr_i(d_sw_addr),
        .sw_wr_data_i(d_sw_wdata), .sw_rd_data_o(d_sw_rd_data),
        .sw_rd_ack_o(d_sw_rd_ack), .sw_wr_ack_o(d_sw_wr_ack),
        .mem_req_o(d_mem_req), .mem_write_o(d_mem_write), .mem_addr_o(d_mem_addr),
        .mem_wdata_o(d_mem_wdata), .mem_wmask_o(d_mem_wmask), .mem_rdata_i(d_mem_rdata)
    );

    dxt_arbiter #(.WIDTH(128), .DEPTH(128), .SW_WRITABLE(1'b0), .MAX_HW_BURST(4)) u_dct (
        .clk_i(clk), .rst_i(rst),
        .hw_req_i(c_hw_req), .hw_we_i(c_hw_we), .hw_index_i(c_hw_index), .hw_wdata_i(c_hw_wdata),
        .hw_gnt_o(c_hw_gnt), .hw_rvalid_o(c_hw_rvalid), .hw_rdata_o(c_hw_rdata),
        .sw_req_i(c_sw_req), .sw_req_is_wr_i(c_sw_is_wr), .sw_addr_i(c_sw_addr),
        .sw_wr_data_i(c_sw_wdata), .sw_rd_data_o(c_sw_rd_data),
        .sw_rd_ack_o(c_sw_rd_ack), .sw_wr_ack_o(c_sw_wr_ack),
        .mem_req_o(c_mem_req), .mem_write_o(c_mem_write), .mem_addr_o(c_mem_addr),
        .mem_wdata_o(c_mem_wdata), .mem_wmask_o(c_mem_wmask), .mem_rdata_i(c_mem_rdata)
    );

    dxt_arbiter_chk u_dat_chk (.clk_i(clk), .rst_i(rst), .sw_req_i(d_sw_req),
                               .sw_rd_ack_i(d_sw_rd_ack), .sw_wr_ack_i(d_sw_wr_ack));
    dxt_arbiter_chk u_dct_chk (.clk_i(clk), .rst_i(rst), .sw_req_i(c_sw_req),
                               .sw_rd_ack_i(c_sw_rd_ack), .sw_wr_ack_i(c_sw_wr_ack));

    // Behavioural single-port RAMs with one-cycle read latency and bit write mask.
    always @(posedge clk) begin
        if (load) begin
            dat_mem[3] <= DAT3;
            dat_mem[5] <= DAT5;
            dct_mem[7] <= DCT7;
        end else begin
            if (d_mem_req) begin
                if (d_mem_write)
                    dat_mem[d_mem_addr] <= (dat_mem[d_mem_addr] & ~d_mem_wmask) | (d_mem_wdata & d_mem_wmask);
                else
                    d_mem_rdata <= dat_mem[d_mem_addr];
            end
            if (c_mem_req) begin
                c_req_count <= c_req_count + 1;
                if (c_mem_write)
                    dct_mem[c_mem_addr] <= (dct_mem[c_mem_addr] & ~c_mem_wmask) | (c_mem_wdata & c_mem_wmask);
                else
                    c_mem_rdata <= dct_mem[c_mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: response with nothing expected (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever a DUT presents a response.
    always @(negedge clk) begin : monitor
        sw_exp_t se;
        hw_exp_t he;
        int      wc;
        if (d_sw_rd_ack || d_sw_wr_ack)
            check("dat_acks_exclusive", 128'(d_sw_rd_ack & d_sw_wr_ack), 128'd0);
        if (d_sw_rd_ack) begin
            if (d_rd_q.size() == 0) unexpected("dat_rd_ack");
            else begin
                se = d_rd_q.pop_front();
                check("dat_rd_data", 128'(d_sw_rd_data), 128'(se.data));
                check("dat_rd_cycle", 128'(cyc), 128'(se.cyc));
            end
        end
        if (d_sw_wr_ack) begin
            if (d_wr_q.size() == 0) unexpected("dat_wr_ack");
            else begin
                wc = d_wr_q.pop_front();
                check("dat_wr_cycle", 128'(cyc), 128'(wc));
            end
        end
        if (d_hw_rvalid) begin
            if (d_hw_q.size() == 0) unexpected("dat_hw_rvalid");
            else begin
                he = d_hw_q.pop_front();
                check("dat_hw_rdata", 128'(d_hw_rdata), 128'(he.data));
                check("dat_hw_cycle", 128'(cyc), 128'(he.cyc));
            end
        end
        if (c_sw_rd_ack) begin
            if (c_rd_q.size() == 0) unexpected("dct_rd_ack");
            else begin
                se = c_rd_q.pop_front();
                check("dct_rd_data", 128'(c_sw_rd_data), 128'(se.data));
                check("dct_rd_cycle", 128'(cyc), 128'(se.cyc));
            end
        end
        if (c_sw_wr_ack) begin
            if (c_wr_q.size() == 0) unexpected("dct_wr_ack");
            else begin
                wc = c_wr_q.pop_front();
                check("dct_wr_cycle", 128'(cyc), 128'(wc));
            end
        end
    end

    initial begin : stimulus
        int n;
        int snap;
        logic [6:0] gnt_pat;
        gnt_pat = 7'b101_1111;

        tick();
        tick();
        @(negedge clk);
        check("rst_dat_flags", 128'({d_hw_rvalid, d_sw_rd_ack, d_sw_wr_ack, d_mem_req, d_mem_write}), 128'd0);
        check("rst_dat_rd_data", 128'(d_sw_rd_data), 128'd0);
        check("rst_dat_hw_rdata", 128'(d_hw_rdata), 128'd0);
        check("rst_dct_flags", 128'({c_hw_rvalid, c_sw_rd_ack, c_sw_wr_ack, c_mem_req}), 128'd0);
        tick();
        rst = 1'b0;
        load = 1'b0;
        tick();

        // Idle software read of entry 5 word 1
        n = cyc;
        d_sw_req = 1'b1; d_sw_is_wr = 1'b0; d_sw_addr = 10'h02C;
        d_rd_q.push_back('{data: 32'hAAAA_BBBB, cyc: n + 3});
        tick();
        d_sw_req = 1'b0;
        @(negedge clk);
        check("sw_rd_issue", 128'({d_mem_req, d_mem_write, d_mem_addr}), 128'({1'b1, 1'b0, 7'd5}));
        repeat (4) tick();

        // Software write of the low word of entry 5
        n = cyc;
        d_sw_req = 1'b1; d_sw_is_wr = 1'b1; d_sw_addr = 10'h028; d_sw_wdata = 32'hDEAD_BEEF;
        d_wr_q.push_back(n + 2);
        tick();
        d_sw_req = 1'b0;
        @(negedge clk);
        check("sw_wr_strobe", 128'({d_mem_req, d_mem_write, d_mem_addr}), 128'({1'b1, 1'b1, 7'd5}));
        check("sw_wr_mask", 128'(d_mem_wmask), 128'(64'h0000_0000_FFFF_FFFF));
        check("sw_wr_data", 128'(d_mem_wdata), 128'(64'hDEAD_BEEF_DEAD_BEEF));
        repeat (3) tick();
        d_hw_req = 1'b1; d_hw_we = 1'b0; d_hw_index = 7'd5;
        @(negedge clk);
        check("hw_rd5_gnt", 128'(d_hw_gnt), 128'd1);
        d_hw_q.push_back('{data: 64'hAAAA_BBBB_DEAD_BEEF, cyc: cyc + 1});
        tick();
        d_hw_req = 1'b0;
        repeat (3) tick();

        // Starvation guard: continuous hardware writes with software read pending
        n = cyc;
        d_sw_req = 1'b1; d_sw_is_wr = 1'b0; d_sw_addr = 10'h018;
        d_rd_q.push_back('{data: 32'hCCCC_4444, cyc: n + 7});
        d_hw_req = 1'b1; d_hw_we = 1'b1; d_hw_index = 7'd10;
        for (int k = 0; k < 7; k++) begin
            d_hw_wdata = 64'(k + 1);
            @(negedge clk);
            check($sformatf("burst_gnt_%0d", k), 128'(d_hw_gnt), 128'(gnt_pat[k]));
            if (k == 5)
                check("burst_sw_issue", 128'({d_mem_req, d_mem_write, d_mem_addr}), 128'({1'b1, 1'b0, 7'd3}));
            tick();
            d_sw_req = 1'b0;
        end
        d_hw_req = 1'b0; d_hw_we = 1'b0;
        repeat (3) tick();
        d_hw_req = 1'b1; d_hw_index = 7'd10;
        d_hw_q.push_back('{data: 64'd7, cyc: cyc + 1});
        tick();
        d_hw_req = 1'b0;
        repeat (3) tick();

        // Hardware read of entry 3 in the SW_RD cycle of a software read
        n = cyc;
        d_sw_req = 1'b1; d_sw_is_wr = 1'b0; d_sw_addr = 10'h02C;
        d_rd_q.push_back('{data: 32'hAAAA_BBBB, cyc: n + 3});
        tick();
        d_sw_req = 1'b0;
        tick();
        d_hw_req = 1'b1; d_hw_we = 1'b0; d_hw_index = 7'd3;
        @(negedge clk);
        check("swrd_hw_gnt", 128'(d_hw_gnt), 128'd1);
        d_hw_q.push_back('{data: DAT3, cyc: n + 3});
        tick();
        d_hw_req = 1'b0;
        repeat (3) tick();

        // Reset while in SW_RD drops the request
        d_sw_req = 1'b1; d_sw_is_wr = 1'b0; d_sw_addr = 10'h02C;
        tick();
        d_sw_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_flags", 128'({d_hw_gnt, d_hw_rvalid, d_sw_rd_ack, d_sw_wr_ack, d_mem_req}), 128'd0);
        check("rstmid_rd_data", 128'(d_sw_rd_data), 128'd0);
        repeat (4) tick();
        n = cyc;
        d_sw_req = 1'b1; d_sw_is_wr = 1'b0; d_sw_addr = 10'h018;
        d_rd_q.push_back('{data: 32'hCCCC_4444, cyc: n + 3});
        tick();
        d_sw_req = 1'b0;
        repeat (5) tick();

        // DCT: software write is acked but never reaches the RAM
        n = cyc;
        snap = c_req_count;
        c_sw_req = 1'b1; c_sw_is_wr = 1'b1; c_sw_addr = 11'h078; c_sw_wdata = 32'h5A5A_5A5A;
        c_wr_q.push_back(n + 2);
        tick();
        c_sw_req = 1'b0;
        @(negedge clk);
        check("dct_wr_no_strobe", 128'(c_mem_req), 128'd0);
        repeat (4) tick();
        check("dct_wr_req_count", 128'(c_req_count), 128'(snap));
        check("dct_mem_unchanged", dct_mem[7], DCT7);
        n = cyc;
        c_sw_req = 1'b1; c_sw_is_wr = 1'b0; c_sw_addr = 11'h078;
        c_rd_q.push_back('{data: 32'h3333_3333, cyc: n + 3});
        tick();
        c_sw_req = 1'b0;
        repeat (5) tick();

        check("dat_rd_q_drained", 128'(d_rd_q.size()), 128'd0);
        check("dat_wr_q_drained", 128'(d_wr_q.size()), 128'd0);
        check("dat_hw_q_drained", 128'(d_hw_q.size()), 128'd0);
        check("dct_rd_q_drained", 128'(c_rd_q.size()), 128'd0);
        check("dct_wr_q_drained", 128'(c_wr_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
